// File: rtl/sw_debounce.sv
// Eight-switch debouncer: 2-flop synchronizer, per-bit saturating run counter,
// registered rise/fall edge pulses and a combined change strobe.
module sw_debounce_lane #(
  parameter int              CNT_W     = 20,
  parameter logic [CNT_W-1:0] DB_CYCLES = 20'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic out,
  output logic rise,
  output logic fall,
  output logic flip
);
  localparam logic [CNT_W-1:0] LAST = DB_CYCLES - CNT_W'(1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             out_q, out_d, rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = sw;
    sync2_d = sync1_q;
    cnt_d   = '0;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Any return to match drops the run; no credit survives a glitch.
    if (sync2_q != out_q) begin
      if (cnt_q == LAST) begin
        out_d  = sync2_q;
        rise_d = sync2_q;
        fall_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign flip = rise_d | fall_d;
endmodule

module sw_debounce #(
  parameter int              CNT_W     = 20,
  parameter logic [CNT_W-1:0] DB_CYCLES = 20'd1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  output logic [7:0] sw_out,
  output logic [7:0] sw_rise,
  output logic [7:0] sw_fall,
  output logic       changed
);
  localparam int NUM_LANES = 8;

  logic [NUM_LANES-1:0] flip;
  logic                 changed_q, changed_d;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sw_debounce_lane #(.CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .sw   (sw[i]),
      .out  (sw_out[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i]),
      .flip (flip[i])
    );
  end

  always_comb changed_d = |flip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) changed_q <= 1'b0;
    else     changed_q <= changed_d;
  end

  assign changed = changed_q;
endmodule
